// File: rtl/arb_4to1_32bit.sv
// rtl/arb_4to1_32bit.sv - round-robin 4:1 arbiter driving an external mux select, with a registered valid/ready output stage
module arb_4to1_32bit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  Req,
  output logic [3:0]  Ack,
  output logic [1:0]  Select,
  input  logic [31:0] MuxOut,
  output logic [31:0] DataOut,
  output logic        DataValid,
  input  logic        DataReady
);

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  last_grant;
  logic [1:0]  winner;
  logic        slot_free;
  logic        capture;

  // The output register can take a word if it is empty or being drained this cycle.
  assign slot_free = !DataValid || DataReady;
  assign capture   = (state == CAPTURE) && slot_free;

  // Round-robin pick: scan from the channel after the last grant, wrapping mod 4.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    winner = last_grant;
    found  = 1'b0;
    idx    = last_grant;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && Req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Next-state logic: leave IDLE on any request, leave CAPTURE once the word is taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Req != 4'b0000) state_next = CAPTURE;
      CAPTURE: if (slot_free)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Acknowledge the selected channel exactly in the cycle its word is captured.
  always_comb begin
    Ack = 4'b0000;
    if (capture) Ack[Select] = 1'b1;
  end

  // State register, select register and output stage.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      last_grant <= 2'b11;
      Select     <= 2'b00;
      DataOut    <= 32'h0;
      DataValid  <= 1'b0;
    end else begin
      state <= state_next;
      // Select moves only on entry to CAPTURE so the mux output settles a full cycle before capture.
      if (state == IDLE && Req != 4'b0000) Select <= winner;
      if (capture) begin
        DataOut    <= MuxOut;
        DataValid  <= 1'b1;
        last_grant <= Select;
      end else if (DataValid && DataReady) begin
        DataValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_4to1_32bit.sv
// tb/tb_arb_4to1_32bit.sv - directed self-checking bench for arb_4to1_32bit
module tb_arb_4to1_32bit;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic [1:0]  sel;
  logic [31:0] mux_out;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] in_word [4];

  int total = 0;
  int bad   = 0;

  arb_4to1_32bit dut (
    .Clock     (clk),
    .Reset     (rst),
    .Req       (req),
    .Ack       (ack),
    .Select    (sel),
    .MuxOut    (mux_out),
    .DataOut   (data_out),
    .DataValid (data_valid),
    .DataReady (data_ready)
  );

  // Behavioural stand-in for mux_4to1_32bit.
  assign mux_out = in_word[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] order [6];
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2;
    order[3] = 2'd3; order[4] = 2'd0; order[5] = 2'd1;

    rst = 1'b1;
    req = 4'b0000;
    data_ready = 1'b0;
    in_word[0] = 32'h1000_0000;
    in_word[1] = 32'h2000_0001;
    in_word[2] = 32'h3000_0002;
    in_word[3] = 32'h4000_0003;

    // Reset state
    cyc(); cyc();
    rst = 1'b0;
    mid();
    chk("reset_select", 32'(sel), 32'd0);
    chk("reset_valid", 32'(data_valid), 32'd0);
    chk("reset_dataout", data_out, 32'h0);
    chk("reset_ack", 32'(ack), 32'd0);

    // No requests for 10 cycles: no ack, select held
    for (int i = 0; i < 10; i++) begin
      cyc();
      mid();
      chk("idle_ack", 32'(ack), 32'd0);
      chk("idle_select", 32'(sel), 32'd0);
    end

    // Single request on channel 2
    cyc();
    req = 4'b0100;
    in_word[2] = 32'hDEADBEEF;
    data_ready = 1'b1;
    mid();
    chk("single_ack_n", 32'(ack), 32'd0);
    cyc();
    mid();
    chk("single_select_n1", 32'(sel), 32'd2);
    chk("single_ack_n1", 32'(ack), 32'b0100);
    cyc();
    req = 4'b0000;
    mid();
    chk("single_dataout_n2", data_out, 32'hDEADBEEF);
    chk("single_valid_n2", 32'(data_valid), 32'd1);
    chk("single_ack_n2", 32'(ack), 32'd0);

    // Reset to restore LastGrant=3, then all four channels requesting
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    in_word[2] = 32'h3000_0002;
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      mid();
      chk("rr_idle_ack", 32'(ack), 32'd0);
      if (k > 0) chk("rr_prev_dataout", data_out, in_word[order[k-1]]);
      cyc();
      mid();
      chk("rr_select", 32'(sel), 32'(order[k]));
      chk("rr_ack", 32'(ack), 32'(4'b0001 << order[k]));
      cyc();
    end
    mid();
    chk("rr_last_dataout", data_out, 32'h2000_0001);
    chk("rr_last_valid", 32'(data_valid), 32'd1);

    // Backpressure: DataValid=1, DataReady=0, channel 1 requests (LastGrant=1)
    req = 4'b0010;
    in_word[1] = 32'hCAFEF00D;
    data_ready = 1'b0;
    mid();
    chk("bp_idle_ack", 32'(ack), 32'd0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("bp_select", 32'(sel), 32'd1);
      chk("bp_ack", 32'(ack), 32'd0);
      chk("bp_dataout_held", data_out, 32'h2000_0001);
      chk("bp_valid_held", 32'(data_valid), 32'd1);
      cyc();
    end
    data_ready = 1'b1;
    mid();
    chk("bp_release_ack", 32'(ack), 32'b0010);
    cyc();
    req = 4'b0000;
    mid();
    chk("bp_new_dataout", data_out, 32'hCAFEF00D);
    chk("bp_valid_stays", 32'(data_valid), 32'd1);
    cyc();
    mid();
    chk("drain_valid", 32'(data_valid), 32'd0);
    chk("drain_dataout_kept", data_out, 32'hCAFEF00D);

    // Reset during CAPTURE with channel 3 pending (LastGrant=1 -> picks 3)
    req = 4'b1000;
    cyc();
    mid();
    chk("pre_reset_select", 32'(sel), 32'd3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req = 4'b1001;
    mid();
    chk("post_reset_select", 32'(sel), 32'd0);
    chk("post_reset_valid", 32'(data_valid), 32'd0);
    chk("post_reset_ack", 32'(ack), 32'd0);
    chk("post_reset_dataout", data_out, 32'h0);

    // LastGrant=3 after reset: channel 0 first
    cyc();
    mid();
    chk("prio0_select", 32'(sel), 32'd0);
    chk("prio0_ack", 32'(ack), 32'b0001);
    cyc();

    // LastGrant=0 with Req=1001: channel 3 before channel 0
    mid();
    chk("prio0_dataout", data_out, 32'h1000_0000);
    cyc();
    mid();
    chk("prio3_select", 32'(sel), 32'd3);
    chk("prio3_ack", 32'(ack), 32'b1000);
    cyc();
    mid();
    chk("prio3_dataout", data_out, 32'h4000_0003);
    cyc();
    mid();
    chk("prio_back0_select", 32'(sel), 32'd0);
    chk("prio_back0_ack", 32'(ack), 32'b0001);
    cyc();
    req = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
